// File: rtl/nonce_dispatcher.sv
// Nonce dispatcher: hands consecutive nonces to a pool of double-hash cores and
// funnels each core's h_out to memory at OUT_BASE+nonce through one write port.
module nonce_dispatcher #(
   parameter int          NUM_CORES  = 4,
   parameter int          NUM_NONCES = 16,
   parameter logic [15:0] OUT_BASE   = 16'h0000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    done,
   output logic [NUM_CORES-1:0]    core_start,
   output logic [32*NUM_CORES-1:0] core_nonce,
   input  logic [NUM_CORES-1:0]    core_done,
   input  logic [32*NUM_CORES-1:0] core_h_out,
   output logic                    mem_we,
   output logic [15:0]             mem_addr,
   output logic [31:0]             mem_write_data
);

   localparam logic [15:0] LAST_NONCE = 16'(NUM_NONCES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state, state_next;
   logic [15:0]          next_nonce, written_count;
   logic [NUM_CORES-1:0] busy, pending, strobe_hold;
   logic [NUM_CORES-1:0] disp_oh, grant_oh, collect;
   logic [1:0]           age [NUM_CORES];
   logic [15:0]          nonce_q [NUM_CORES];
   logic [15:0]          grant_nonce;
   logic [31:0]          grant_data;

   function automatic logic [1:0] sat_inc2(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (written_count == LAST_NONCE) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign done = (state == IDLE);

   // A core that wins the write port this cycle is free to take a new nonce in the same cycle.
   always_comb begin
      grant_oh    = '0;
      disp_oh     = '0;
      collect     = '0;
      grant_nonce = '0;
      grant_data  = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         if (state == RUN && pending[j] && grant_oh == '0) begin
            grant_oh[j] = 1'b1;
            grant_nonce = nonce_q[j];
            grant_data  = core_h_out[32*j +: 32];
         end
      end
      for (int j = 0; j < NUM_CORES; j++) begin
         if (state == RUN && next_nonce < LAST_NONCE && disp_oh == '0 &&
             !busy[j] && (!pending[j] || grant_oh[j]))
            disp_oh[j] = 1'b1;
      end
      for (int j = 0; j < NUM_CORES; j++)
         collect[j] = busy[j] && (age[j] == 2'd3) && core_done[j];
   end

   always_comb begin
      core_nonce = '0;
      for (int j = 0; j < NUM_CORES; j++)
         core_nonce[32*j +: 32] = {16'h0000, disp_oh[j] ? next_nonce : nonce_q[j]};
   end

   assign core_start = disp_oh | strobe_hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         next_nonce     <= '0;
         written_count  <= '0;
         busy           <= '0;
         pending        <= '0;
         strobe_hold    <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         for (int j = 0; j < NUM_CORES; j++) begin
            age[j]     <= '0;
            nonce_q[j] <= '0;
         end
      end else begin
         strobe_hold <= disp_oh;
         mem_we      <= |grant_oh;
         if (|grant_oh) begin
            mem_addr       <= OUT_BASE + grant_nonce;
            mem_write_data <= grant_data;
         end
         if (state == IDLE && start) begin
            next_nonce    <= '0;
            written_count <= '0;
         end else begin
            if (|disp_oh)  next_nonce    <= next_nonce + 16'd1;
            if (|grant_oh) written_count <= written_count + 16'd1;
         end
         // age masks the done level left over from the previous job for three cycles
         for (int j = 0; j < NUM_CORES; j++) begin
            if (disp_oh[j]) begin
               busy[j]    <= 1'b1;
               age[j]     <= 2'd1;
               nonce_q[j] <= next_nonce;
            end else begin
               if (busy[j])    age[j]  <= sat_inc2(age[j]);
               if (collect[j]) busy[j] <= 1'b0;
            end
            if (collect[j])       pending[j] <= 1'b1;
            else if (grant_oh[j]) pending[j] <= 1'b0;
         end
      end
   end

endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Schedules a pool of NUM_CORES phase-2/3 double-hash cores across NUM_NONCES consecutive nonces (0..NUM_NONCES-1).
- Hands each idle core the next nonce and collects each core's 32-bit h_out when it finishes.
- Writes each result to memory at OUT_BASE+nonce through a single shared write port.
- Sits between the top-level bitcoin hash controller (after phase 1 has produced h_in) and the core array.

Parameters:
- NUM_CORES, 4, number of hash cores driven; 1..16.
- NUM_NONCES, 16, nonces processed per run; 1..65535.
- OUT_BASE, 16'h0000, memory word address of the result for nonce 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored unless idle.
- done  out  1  high while idle; low from the cycle after an accepted start until the last result is written.
- core_start  out  NUM_CORES  per-core start strobe.
- core_nonce  out  32*NUM_CORES  per-core nonce; core j uses bits [32j+31:32j].
- core_done  in  NUM_CORES  per-core done level.
- core_h_out  in  32*NUM_CORES  per-core h_out; packed the same way as core_nonce.
- mem_we  out  1  result write enable.
- mem_addr  out  16  result write address.
- mem_write_data  out  32  result data.

Behaviour:
- Reset values: done=1, core_start=0, core_nonce=0, mem_we=0, mem_addr=0, mem_write_data=0. All internal busy/pending flags clear, next_nonce=0, written_count=0, state=IDLE.
- Cores must be reset in the same cycle as this block; after reset every core counts as idle.
- States:
  - IDLE: done=1. start -> RUN, with next_nonce=0 and written_count=0.
  - RUN: dispatch and collect as described below. Go to IDLE the cycle after the write that makes written_count=NUM_NONCES.
- Dispatch:
  - At most one dispatch per cycle, to the lowest-index core that is not busy and has no pending result, while next_nonce<NUM_NONCES.
  - Dispatch at cycle t: core_nonce[j]=next_nonce from t (held stable until the next dispatch to j); core_start[j]=1 for exactly cycles t and t+1; busy[j] set; next_nonce++.
  - The 2-cycle strobe is mandatory: a core leaving DONE needs start in DONE and again in PHASE2. A core already in PHASE2 ignores the second cycle.
- Collect:
  - core_done[j] is ignored until cycle t+3 after dispatch. This masks the stale done level.
  - From then on, busy[j] && core_done[j] sets pending[j] and clears busy[j].
- Write arbitration:
  - Each cycle, the lowest-index pending core wins the port.
  - Registered output the next cycle: mem_we=1, mem_addr=OUT_BASE+core_nonce[j] (16-bit, wraps modulo 2^16), mem_write_data=core_h_out[j]; pending[j] clears; written_count++.
  - Losers stay pending; their core holds h_out because it stays in DONE and is not re-dispatched.
- Throughput: a core whose result is written in cycle c may be re-dispatched in cycle c (its pending flag clears that cycle).
- Simultaneous completion of k cores gives k writes in k consecutive cycles, in ascending core index.
- NUM_NONCES<NUM_CORES: cores above index NUM_NONCES-1 are never started.
- start while in RUN is ignored; no restart or abort.
- reset mid-run: return to reset values next edge. No partial writes are completed, and no write issues in the reset cycle.
- Results are written in completion order, not nonce order; only the address identifies the nonce.

Test Plan:
- Reset then idle: hold reset 2 cycles with start=0 -> done=1, mem_we=0, core_start=0 for 20 cycles.
- Basic run, NUM_CORES=4, NUM_NONCES=16, cores modelled as a fixed 147-cycle latency: pulse start ->
  - core_start 2-cycle pulses on cores 0,1,2,3 in cycles 1,2,3,4 with nonces 0,1,2,3;
  - 16 writes to addresses 0..15 with data = model h_out;
  - done rises after the 16th write.
- Simultaneous completion: force core_done on cores 1 and 3 in the same cycle -> writes from core 1 then core 3 in consecutive cycles; core 3 gets no new start until its write.
- Stale-done masking: core model keeps core_done=1 for one cycle after start -> no write for that core until its real completion.
- Small job, NUM_NONCES=2, OUT_BASE=16'h0010: only cores 0 and 1 start; writes go to 16'h0010 and 16'h0011; core_start[3:2] stays 0.
- Mid-run reset: assert reset after 5 writes -> outputs return to reset values next cycle. A new start then restarts from nonce 0 at address OUT_BASE.
